// File: rtl/dvp_frame_tx.sv
// ---------------------------------------------------------------------------
// dvp_frame_tx
//   Camera-side DVP transmitter. Produces vsync / href / 8-bit YCbCr422 bytes
//   (Y0, Cb, Cr, Y1 per pixel pair) on pclk so the capture path can run
//   without a camera. Pixel pairs come from a 32-bit valid/ready word stream
//   through a one-entry hold register, or from an internal grey-bar pattern.
//
// Ports
//   pclk         byte clock, rising edge
//   reset        synchronous, active-high
//   enable       start / continue frames (sampled in IDLE and at frame end)
//   src_sel      0 = word stream, 1 = grey bars (captured at frame start)
//   word_in      {Y0, Cb, Cr, Y1}
//   word_valid   word_in valid
//   word_ready   hold register can accept a word
//   vsync        frame sync, active-high
//   href         active byte qualifier
//   data_out     byte stream, 8'h00 whenever href = 0
//   frame_start  one-cycle pulse on the first vsync cycle of a frame
//   frame_count  frames started (wraps)
//   underrun     one-cycle pulse when a stream pair starts with hold empty
// ---------------------------------------------------------------------------
module dvp_frame_tx #(
  parameter int H_ACTIVE_PAIRS = 320,
  parameter int H_BLANK        = 144,
  parameter int V_ACTIVE       = 480,
  parameter int VSYNC_LINES    = 3,
  parameter int V_BACK         = 17,
  parameter int V_FRONT        = 10,
  parameter int BAR_PAIRS      = H_ACTIVE_PAIRS / 8
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        src_sel,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data_out,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic        underrun
);

  localparam int ACT_BYTES = 4 * H_ACTIVE_PAIRS;
  localparam int LINE_LEN  = ACT_BYTES + H_BLANK;
  localparam int HC_W      = $clog2(LINE_LEN + 1);
  localparam int V_MAX_AB  = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
  localparam int V_MAX_SF  = (VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT;
  localparam int V_MAX     = (V_MAX_AB > V_MAX_SF) ? V_MAX_AB : V_MAX_SF;
  localparam int VL_W      = $clog2(V_MAX + 1);
  localparam int BAR_STEP  = (BAR_PAIRS < 1) ? 1 : BAR_PAIRS;
  localparam int BC_W      = $clog2(BAR_STEP + 1);

  localparam logic [HC_W-1:0] HC_LAST = HC_W'(LINE_LEN - 1);
  localparam logic [HC_W-1:0] HC_ACT  = HC_W'(ACT_BYTES);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BAR_STEP - 1);
  localparam logic [31:0]     BLACK   = 32'h10808010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  // Walks forward past phases configured with zero lines.
  function automatic state_t skip_empty(input state_t s);
    state_t t;
    t = s;
    if (t == S_VSYNC  && VSYNC_LINES == 0) t = S_VBACK;
    if (t == S_VBACK  && V_BACK      == 0) t = S_ACTIVE;
    if (t == S_ACTIVE && V_ACTIVE    == 0) t = S_VFRONT;
    if (t == S_VFRONT && V_FRONT     == 0) t = S_IDLE;
    return t;
  endfunction

  function automatic logic [VL_W-1:0] last_line(input state_t s);
    int n;
    case (s)
      S_VSYNC:  n = VSYNC_LINES;
      S_VBACK:  n = V_BACK;
      S_ACTIVE: n = V_ACTIVE;
      S_VFRONT: n = V_FRONT;
      default:  n = 1;
    endcase
    return VL_W'((n > 0) ? n - 1 : 0);
  endfunction

  // The r_state/r_hcount/r_vline registers run one cycle ahead of the
  // registered outputs: they hold the position whose outputs are produced
  // on the next edge. That lookahead lets word_ready (a registered output)
  // open one cycle before each pair start. S_IDLE here also marks "frame
  // just ended", so enable is sampled on the edge right after VFRONT.
  state_t           r_state;
  logic [HC_W-1:0]  r_hcount;
  logic [VL_W-1:0]  r_vline;
  logic             r_src_pat;
  logic             r_hold_full;
  logic [31:0]      r_hold;
  logic [23:0]      r_shift;
  logic [2:0]       r_bar;
  logic [BC_W-1:0]  r_bar_cnt;
  logic             r_word_ready;
  logic             r_vsync;
  logic             r_href;
  logic [7:0]       r_data;
  logic             r_frame_start;
  logic [15:0]      r_frame_count;
  logic             r_underrun;

  logic             w_frame_begin;
  state_t           w_cur_state;
  logic [HC_W-1:0]  w_cur_hc;
  logic [VL_W-1:0]  w_cur_vl;
  state_t           w_nxt_state;
  logic [HC_W-1:0]  w_nxt_hc;
  logic [VL_W-1:0]  w_nxt_vl;
  logic             w_cur_href;
  logic             w_cur_pair;
  logic             w_nxt_pair;
  logic             w_pat;
  logic             w_xfer;
  logic             w_load;
  logic             w_hold_full_nxt;
  logic [2:0]       w_bar_cur;
  logic [BC_W-1:0]  w_cnt_cur;
  logic [2:0]       w_bar_nxt;
  logic [BC_W-1:0]  w_cnt_nxt;
  logic [7:0]       w_y;
  logic [31:0]      w_pair_word;
  logic [7:0]       w_data_nxt;
  logic [23:0]      w_shift_nxt;

  // Next-state / next-output logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_frame_begin = (r_state == S_IDLE) && enable;
    w_cur_state   = r_state;
    w_cur_hc      = r_hcount;
    w_cur_vl      = r_vline;
    if (w_frame_begin) begin
      w_cur_state = skip_empty(S_VSYNC);
      w_cur_hc    = '0;
      w_cur_vl    = '0;
    end

    w_nxt_state = w_cur_state;
    w_nxt_hc    = w_cur_hc;
    w_nxt_vl    = w_cur_vl;
    if (w_cur_state != S_IDLE) begin
      if (w_cur_hc != HC_LAST) begin
        w_nxt_hc = w_cur_hc + 1'b1;
      end else begin
        w_nxt_hc = '0;
        if (w_cur_vl != last_line(w_cur_state)) begin
          w_nxt_vl = w_cur_vl + 1'b1;
        end else begin
          w_nxt_vl = '0;
          case (w_cur_state)
            S_VSYNC:  w_nxt_state = skip_empty(S_VBACK);
            S_VBACK:  w_nxt_state = skip_empty(S_ACTIVE);
            S_ACTIVE: w_nxt_state = skip_empty(S_VFRONT);
            default:  w_nxt_state = S_IDLE;
          endcase
        end
      end
    end

    w_cur_href = (w_cur_state == S_ACTIVE) && (w_cur_hc < HC_ACT);
    w_cur_pair = w_cur_href && (w_cur_hc[1:0] == 2'b00);
    w_nxt_pair = (w_nxt_state == S_ACTIVE) && (w_nxt_hc < HC_ACT) &&
                 (w_nxt_hc[1:0] == 2'b00);

    // Source follows src_sel live while idle and freezes once a frame runs.
    w_pat           = (r_state == S_IDLE) ? src_sel : r_src_pat;
    w_xfer          = word_valid && r_word_ready && !w_pat;
    w_load          = w_cur_pair && !w_pat;
    w_hold_full_nxt = (r_hold_full && !w_load) || w_xfer;

    // Bar counters restart at every line start.
    w_bar_cur = (w_cur_hc == '0) ? 3'd0 : r_bar;
    w_cnt_cur = (w_cur_hc == '0) ? '0 : r_bar_cnt;
    w_bar_nxt = r_bar;
    w_cnt_nxt = r_bar_cnt;
    if (w_cur_pair) begin
      if (w_cnt_cur == BC_LAST) begin
        w_cnt_nxt = '0;
        w_bar_nxt = (w_bar_cur == 3'd7) ? 3'd7 : w_bar_cur + 3'd1;
      end else begin
        w_cnt_nxt = w_cnt_cur + 1'b1;
        w_bar_nxt = w_bar_cur;
      end
    end

    w_y = 8'h10 + ({5'b0, w_bar_cur} * 8'h1C);
    if (w_pat)            w_pair_word = {w_y, 8'h80, 8'h80, w_y};
    else if (r_hold_full) w_pair_word = r_hold;
    else                  w_pair_word = BLACK;

    w_data_nxt  = 8'h00;
    w_shift_nxt = r_shift;
    if (w_cur_pair) begin
      w_data_nxt  = w_pair_word[31:24];
      w_shift_nxt = w_pair_word[23:0];
    end else if (w_cur_href) begin
      w_data_nxt  = r_shift[23:16];
      w_shift_nxt = {r_shift[15:0], 8'h00};
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state       <= S_IDLE;
      r_hcount      <= '0;
      r_vline       <= '0;
      r_src_pat     <= 1'b0;
      r_hold_full   <= 1'b0;
      r_bar         <= 3'd0;
      r_bar_cnt     <= '0;
      r_word_ready  <= 1'b0;
      r_vsync       <= 1'b0;
      r_href        <= 1'b0;
      r_data        <= 8'h00;
      r_frame_start <= 1'b0;
      r_frame_count <= 16'h0000;
      r_underrun    <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_hcount      <= w_nxt_hc;
      r_vline       <= w_nxt_vl;
      if (r_state == S_IDLE) r_src_pat <= src_sel;
      r_hold_full   <= w_hold_full_nxt;
      r_bar         <= w_bar_nxt;
      r_bar_cnt     <= w_cnt_nxt;
      r_word_ready  <= !w_pat && (!w_hold_full_nxt || w_nxt_pair);
      r_vsync       <= (w_cur_state == S_VSYNC);
      r_href        <= w_cur_href;
      r_data        <= w_data_nxt;
      r_frame_start <= w_frame_begin;
      r_frame_count <= r_frame_count + {15'd0, w_frame_begin};
      r_underrun    <= w_load && !r_hold_full;
    end
  end

  // NOTE: pure datapath registers carry no reset; they are only read when
  // r_hold_full or the line position says their contents are valid.
  always_ff @(posedge pclk) begin
    if (w_xfer) r_hold <= word_in;
    r_shift <= w_shift_nxt;
  end

  assign word_ready  = r_word_ready;
  assign vsync       = r_vsync;
  assign href        = r_href;
  assign data_out    = r_data;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_dvp_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_dvp_frame_tx
//   Directed bench for dvp_frame_tx with a small geometry: 4 pairs + 4 blank
//   bytes per line (20 cycles), 1 vsync line, 1 back line, 2 active lines,
//   1 front line -> 100-cycle frames. Time t counts cycles from the first
//   vsync cycle of a frame; outputs are sampled 1 time unit after pclk rises.
// ---------------------------------------------------------------------------
module tb_dvp_frame_tx;

  localparam int LINE  = 20;
  localparam int FRAME = 100;

  logic        pclk;
  logic        reset;
  logic        enable;
  logic        src_sel;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        vsync;
  logic        href;
  logic [7:0]  data_out;
  logic        frame_start;
  logic [15:0] frame_count;
  logic        underrun;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] src_words [4];
  int          src_idx;
  int          src_n;

  dvp_frame_tx #(
    .H_ACTIVE_PAIRS (4),
    .H_BLANK        (4),
    .V_ACTIVE       (2),
    .VSYNC_LINES    (1),
    .V_BACK         (1),
    .V_FRONT        (1),
    .BAR_PAIRS      (1)
  ) dut (
    .pclk        (pclk),
    .reset       (reset),
    .enable      (enable),
    .src_sel     (src_sel),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .vsync       (vsync),
    .href        (href),
    .data_out    (data_out),
    .frame_start (frame_start),
    .frame_count (frame_count),
    .underrun    (underrun)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Expected frame geometry relative to the first vsync cycle.
  function automatic logic exp_vsync(input int t);
    return (t % FRAME) < LINE;
  endfunction

  function automatic logic exp_href(input int t);
    int ln;
    int hc;
    ln = (t % FRAME) / LINE;
    hc = (t % FRAME) % LINE;
    return (ln == 2 || ln == 3) && hc < 16;
  endfunction

  function automatic logic [7:0] exp_pat(input int t);
    int hc;
    logic [7:0] y;
    hc = (t % FRAME) % LINE;
    if (!exp_href(t)) return 8'h00;
    y = 8'h10 + 8'(hc / 4) * 8'h1C;
    return (hc % 4 == 0 || hc % 4 == 3) ? y : 8'h80;
  endfunction

  // One clock; also plays the stream source (a word is consumed on an edge
  // where valid and ready were both high beforehand).
  task automatic tick();
    logic hs;
    hs = word_valid && word_ready;
    @(posedge pclk);
    #1;
    if (hs) begin
      src_idx++;
      if (src_idx < src_n) begin
        word_in = src_words[src_idx];
      end else begin
        word_valid = 1'b0;
        word_in    = 32'h0;
      end
    end
  endtask

  // Reset, then enable; returns at t = 0 (first vsync cycle).
  task automatic start_frame(input logic sel, input int n_words);
    reset      = 1'b1;
    enable     = 1'b0;
    word_valid = 1'b0;
    word_in    = 32'h0;
    src_idx    = 0;
    src_n      = 0;
    tick();
    tick();
    reset      = 1'b0;
    enable     = 1'b1;
    src_sel    = sel;
    src_n      = n_words;
    word_valid = (n_words > 0);
    word_in    = (n_words > 0) ? src_words[0] : 32'h0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; src_sel = 1'b1; word_valid = 1'b0; word_in = 32'h0;
    src_idx = 0; src_n = 0;
    tick();
    tick();
    n_checks++; if (vsync !== 1'b0) $display("FAIL reset_vsync: got %b want 0", vsync); else n_pass++;
    n_checks++; if (href !== 1'b0) $display("FAIL reset_href: got %b want 0", href); else n_pass++;
    n_checks++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", data_out); else n_pass++;
    n_checks++; if (frame_start !== 1'b0) $display("FAIL reset_fs: got %b want 0", frame_start); else n_pass++;
    n_checks++; if (frame_count !== 16'h0) $display("FAIL reset_count: got %h want 0000", frame_count); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
    n_checks++; if (word_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", word_ready); else n_pass++;
  endtask

  task automatic test_timing();
    start_frame(1'b1, 0);
    for (int t = 0; t < FRAME; t++) begin
      n_checks++; if (vsync !== exp_vsync(t)) $display("FAIL timing_vsync t=%0d: got %b want %b", t, vsync, exp_vsync(t)); else n_pass++;
      n_checks++; if (href !== exp_href(t)) $display("FAIL timing_href t=%0d: got %b want %b", t, href, exp_href(t)); else n_pass++;
      n_checks++; if (frame_start !== (t == 0)) $display("FAIL timing_fs t=%0d: got %b want %b", t, frame_start, t == 0); else n_pass++;
      n_checks++; if (frame_count !== 16'd1) $display("FAIL timing_count t=%0d: got %0d want 1", t, frame_count); else n_pass++;
      n_checks++; if (vsync && href) $display("FAIL timing_overlap t=%0d: got vsync=1 href=1 want not both", t); else n_pass++;
      tick();
    end
    n_checks++; if (vsync !== 1'b1) $display("FAIL timing_vsync2: got %b want 1", vsync); else n_pass++;
    n_checks++; if (frame_start !== 1'b1) $display("FAIL timing_fs2: got %b want 1", frame_start); else n_pass++;
    n_checks++; if (frame_count !== 16'd2) $display("FAIL timing_count2: got %0d want 2", frame_count); else n_pass++;
  endtask

  task automatic test_pattern();
    start_frame(1'b1, 0);
    for (int t = 0; t < FRAME; t++) begin
      n_checks++; if (data_out !== exp_pat(t)) $display("FAIL pattern_data t=%0d: got %h want %h", t, data_out, exp_pat(t)); else n_pass++;
      tick();
    end
  endtask

  task automatic test_stream();
    logic [31:0] w;
    logic [7:0]  eb;
    logic        er;
    int          hc;
    src_words[0] = 32'hA1B2C3D4;
    src_words[1] = 32'h01020304;
    src_words[2] = 32'h11121314;
    src_words[3] = 32'h21222324;
    start_frame(1'b0, 4);
    for (int t = 0; t < 3 * LINE; t++) begin
      // Ready while hold is empty, and in the cycle before each pair start.
      er = (t == 0) || (t == 39) || (t == 43) || (t == 47) || (t >= 51);
      n_checks++; if (word_ready !== er) $display("FAIL stream_ready t=%0d: got %b want %b", t, word_ready, er); else n_pass++;
      n_checks++; if (underrun !== 1'b0) $display("FAIL stream_underrun t=%0d: got %b want 0", t, underrun); else n_pass++;
      if (t >= 2 * LINE) begin
        hc = t - 2 * LINE;
        eb = 8'h00;
        if (hc < 16) begin
          w  = src_words[hc / 4];
          eb = w[31 - 8 * (hc % 4) -: 8];
        end
        n_checks++; if (data_out !== eb) $display("FAIL stream_data t=%0d: got %h want %h", t, data_out, eb); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_underrun();
    logic [7:0] eb;
    logic       eu;
    int         hc;
    start_frame(1'b0, 0);
    for (int t = 0; t < 3 * LINE; t++) begin
      hc = t % LINE;
      eu = (t >= 2 * LINE) && hc < 16 && (hc % 4 == 0);
      n_checks++; if (underrun !== eu) $display("FAIL underrun_pulse t=%0d: got %b want %b", t, underrun, eu); else n_pass++;
      n_checks++; if (href !== exp_href(t)) $display("FAIL underrun_href t=%0d: got %b want %b", t, href, exp_href(t)); else n_pass++;
      if (t >= 2 * LINE) begin
        eb = (hc >= 16) ? 8'h00 : ((hc % 4 == 0 || hc % 4 == 3) ? 8'h10 : 8'h80);
        n_checks++; if (data_out !== eb) $display("FAIL underrun_data t=%0d: got %h want %h", t, data_out, eb); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_enable_drop();
    start_frame(1'b1, 0);
    for (int t = 0; t < 150; t++) begin
      n_checks++; if (vsync !== (t < LINE)) $display("FAIL endrop_vsync t=%0d: got %b want %b", t, vsync, t < LINE); else n_pass++;
      n_checks++; if (href !== ((t < FRAME) && exp_href(t))) $display("FAIL endrop_href t=%0d: got %b want %b", t, href, (t < FRAME) && exp_href(t)); else n_pass++;
      n_checks++; if (frame_start !== (t == 0)) $display("FAIL endrop_fs t=%0d: got %b want %b", t, frame_start, t == 0); else n_pass++;
      n_checks++; if (frame_count !== 16'd1) $display("FAIL endrop_count t=%0d: got %0d want 1", t, frame_count); else n_pass++;
      if (t == 45) enable = 1'b0;
      tick();
    end
    enable = 1'b1;
    tick();
    n_checks++; if (vsync !== 1'b1) $display("FAIL endrop_restart_vsync: got %b want 1", vsync); else n_pass++;
    n_checks++; if (frame_start !== 1'b1) $display("FAIL endrop_restart_fs: got %b want 1", frame_start); else n_pass++;
    n_checks++; if (frame_count !== 16'd2) $display("FAIL endrop_restart_count: got %0d want 2", frame_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    start_frame(1'b1, 0);
    for (int t = 0; t < 45; t++) tick();
    n_checks++; if (href !== 1'b1) $display("FAIL rstmid_pre_href: got %b want 1", href); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (href !== 1'b0) $display("FAIL rstmid_href: got %b want 0", href); else n_pass++;
    n_checks++; if (data_out !== 8'h00) $display("FAIL rstmid_data: got %h want 00", data_out); else n_pass++;
    n_checks++; if (frame_count !== 16'd0) $display("FAIL rstmid_count: got %0d want 0", frame_count); else n_pass++;
    n_checks++; if (vsync !== 1'b0) $display("FAIL rstmid_vsync: got %b want 0", vsync); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (frame_start !== 1'b1) $display("FAIL rstmid_fs: got %b want 1", frame_start); else n_pass++;
    n_checks++; if (frame_count !== 16'd1) $display("FAIL rstmid_count1: got %0d want 1", frame_count); else n_pass++;
    for (int t = 0; t < FRAME; t++) begin
      n_checks++; if (vsync !== exp_vsync(t)) $display("FAIL rstmid_vsync t=%0d: got %b want %b", t, vsync, exp_vsync(t)); else n_pass++;
      n_checks++; if (href !== exp_href(t)) $display("FAIL rstmid_href t=%0d: got %b want %b", t, href, exp_href(t)); else n_pass++;
      n_checks++; if (data_out !== exp_pat(t)) $display("FAIL rstmid_data t=%0d: got %h want %h", t, data_out, exp_pat(t)); else n_pass++;
      tick();
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    src_sel    = 1'b1;
    word_in    = 32'h0;
    word_valid = 1'b0;
    src_idx    = 0;
    src_n      = 0;
    test_reset();
    test_timing();
    test_pattern();
    test_stream();
    test_underrun();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dvp_frame_tx.md
Name: dvp_frame_tx

Overview:
- Camera-side DVP transmitter: drives vsync, href and an 8-bit byte stream on pclk, in the YCbCr422 byte order our capture logic expects (Y0, Cb, Cr, Y1).
- Lets the capture path, frame buffer and downstream pinball tracking run in simulation and on the board without the camera.
- Pixel pairs come either from a 32-bit word stream (valid/ready) or from an internal grey-bar pattern.

Parameters:
H_ACTIVE_PAIRS, 320, pixel pairs per active line (4 bytes each; active bytes per line = 4*H_ACTIVE_PAIRS)
H_BLANK, 144, pclk cycles per line with href low after the active bytes
V_ACTIVE, 480, lines with href pulses
VSYNC_LINES, 3, lines with vsync high
V_BACK, 17, blank lines between vsync and the first active line
V_FRONT, 10, blank lines after the last active line
BAR_PAIRS, H_ACTIVE_PAIRS/8, pairs per grey bar in pattern mode

Ports:
pclk  in  1  byte clock; all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  start/continue frames
src_sel  in  1  0 = word stream, 1 = internal pattern (sampled at frame start)
word_in  in  32  {Y0,Cb,Cr,Y1}
word_valid  in  1  word_in valid
word_ready  out  1  hold register can accept a word
vsync  out  1  frame sync, active-high
href  out  1  active byte qualifier
data_out  out  8  byte; 8'h00 whenever href=0
frame_start  out  1  one-cycle pulse on the first vsync cycle of a frame
frame_count  out  16  frames started, wraps 16'hFFFF->0
underrun  out  1  one-cycle pulse when a stream-mode pair starts with the hold register empty

Behaviour:
- LINE_LEN = 4*H_ACTIVE_PAIRS + H_BLANK.
- Counters: hcount (0..LINE_LEN-1) and vline (line within the current phase).
- All outputs are registered.
- Reset: vsync, href, word_ready, frame_start and underrun = 0; data_out = 0; frame_count = 0; hold register empty; state IDLE.
- Reset mid-frame takes effect on the next edge; no partial line completes.
- FSM states and transitions:
  - IDLE: outputs low. If enable=1, next cycle enters VSYNC with hcount=0.
  - VSYNC: vsync=1 for VSYNC_LINES*LINE_LEN cycles. frame_start=1 and frame_count+1 on its first cycle only. Then -> VBACK.
  - VBACK: V_BACK lines, all low. Then -> ACTIVE.
  - ACTIVE: V_ACTIVE lines. href=1 for hcount < 4*H_ACTIVE_PAIRS, low for the following H_BLANK cycles. Then -> VFRONT.
  - VFRONT: V_FRONT lines, all low. At the end: enable=1 -> VSYNC (back-to-back frames); enable=0 -> IDLE.
  - A zero-length phase parameter skips that phase.
- enable deasserted mid-frame: the current frame finishes completely; it is sampled only at the end of VFRONT and in IDLE.
- Byte order: hcount[1:0]=0 emits word[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - The pair word is latched into a shift register on each hcount[1:0]=0 active cycle (pair start).
- Stream mode, hold register:
  - One-entry hold register. word_ready = ~hold_full | pair_start_this_cycle.
  - Transfer occurs when word_valid & word_ready.
  - At pair start, the shift register loads from hold and hold empties. A simultaneous new transfer refills hold in the same cycle.
  - Hold empty at pair start: emit black pair 32'h10808010 and pulse underrun. Line timing never stalls.
  - Hold contents persist across blanking and frames.
  - word_ready is also 1 in IDLE/blanking while hold is empty, so the first word is prefetched.
  - src_sel=1: word_ready=0 and hold is untouched.
- Pattern mode:
  - bar index b (3 bits) resets to 0 at each line start and increments every BAR_PAIRS pairs, saturating at 7.
  - Word = {Y, 8'h80, 8'h80, Y} with Y = 8'h10 + b*8'h1C, giving 8'h10..8'hD4.
- src_sel is captured at frame start; changes mid-frame are ignored.
- vsync and href are never both 1.

Test Plan:
- Use H_ACTIVE_PAIRS=4, H_BLANK=4, V_ACTIVE=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, BAR_PAIRS=1. LINE_LEN=20; frame = 100 cycles.
- Timing: reset, enable=1, src_sel=1 -> frame_start pulses once; vsync high 20 cycles; 20 low; then 2 lines of href high 16 / low 4; 20 low; the next vsync starts exactly 100 cycles after the first; frame_count 0->1->2.
- Pattern: src_sel=1 -> each active line's bytes = 10 80 80 10, 2C 80 80 2C, 48 80 80 48, 64 80 80 64; data_out=00 whenever href=0.
- Stream: src_sel=0, always-valid source of 32'hA1B2C3D4, then 32'h01020304 -> bytes A1 B2 C3 D4 01 02 03 04 in order; underrun never pulses; word_ready drops while hold is full.
- Underrun: word_valid=0 through the whole first active line -> four pairs of 10 80 80 10 with four underrun pulses, one at each pair start; href timing unchanged.
- enable dropped mid-ACTIVE -> frame completes through VFRONT, then IDLE with vsync=0 and no further frame_start; re-assert -> the next frame begins one cycle later.
- Reset asserted mid-line -> next cycle href=0, data_out=0, frame_count=0; after release with enable=1, a full frame starts from VSYNC.
